// File: rtl/router_sync.sv
// router_sync
//   Glue between the 1x3 router's packet-control FSM and its three output
//   FIFOs. Latches the header's destination address, steers the FSM write
//   strobe to the addressed FIFO, returns that FIFO's full flag, reports
//   per-port data availability and soft-resets a FIFO whose data has sat
//   unread for TIMEOUT consecutive cycles.
//
// Ports
//   clock            rising-edge clock
//   resetn           synchronous active-low reset
//   detect_add       header byte present; latch data_in as destination
//   data_in[1:0]     destination address field of the header
//   write_enb_reg    FSM write strobe for the current byte
//   read_enb_0..2    destination read strobes
//   empty_0..2       FIFO empty flags
//   full_0..2        FIFO full flags
//   write_enb[2:0]   one-hot FIFO write enables (bit n -> FIFO n)
//   fifo_full        full flag of the addressed FIFO (0 when address invalid)
//   vld_out_0..2     port n holds readable data
//   soft_reset_0..2  one-cycle soft-reset pulse to FIFO n
module router_sync #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CW      = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
);

  localparam logic [1:0]    ADDR_NONE = 2'b11;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);

  logic [1:0]    addr;
  logic [2:0]    vld;
  logic [2:0]    rd;
  logic [2:0]    soft_reset;
  logic [CW-1:0] cnt [3];

  assign vld = {~empty_2, ~empty_1, ~empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

  assign soft_reset_0 = soft_reset[0];
  assign soft_reset_1 = soft_reset[1];
  assign soft_reset_2 = soft_reset[2];

  // Destination address; 2'b11 means no destination selected.
  always_ff @(posedge clock) begin
    if (!resetn)
      addr <= ADDR_NONE;
    else if (detect_add)
      addr <= data_in;
  end

  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    case (addr)
      2'b00: begin
        write_enb = {2'b00, write_enb_reg};
        fifo_full = full_0;
      end
      2'b01: begin
        write_enb = {1'b0, write_enb_reg, 1'b0};
        fifo_full = full_1;
      end
      2'b10: begin
        write_enb = {write_enb_reg, 2'b00};
        fifo_full = full_2;
      end
      default: begin
        write_enb = '0;
        fifo_full = 1'b0;
      end
    endcase
  end

  // Per-port stall timers: count consecutive valid-but-unread cycles and
  // fire a single-cycle soft reset when the count reaches TIMEOUT, then
  // start a fresh count if data is still pending.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (!resetn || !vld[i] || rd[i]) begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b0;
      end else if (cnt[i] == CNT_LAST) begin
        cnt[i]        <= '0;
        soft_reset[i] <= 1'b1;
      end else begin
        cnt[i]        <= cnt[i] + CW'(1);
        soft_reset[i] <= 1'b0;
      end
    end
  end

endmodule
